jtag_tap_ctrl: RTL

IEEE 1149.1 TAP controller that turns the external JTAG pins into the TAP-state strobes and instruction selects consumed by the debug top level. It runs the 16-state TAP FSM, holds the 4-bit instruction register, and implements the BYPASS and IDCODE data registers. It forwards TDI to the debug top level and multiplexes the debug top level's TDO onto the pin. It sits between the chip-level JTAG pads and the debug top level, entirely in the TCK domain.

---
 rtl/jtag_tap_pkg.sv | 48 ++++
 rtl/jtag_tap_fsm.sv | 57 +++++
 rtl/jtag_tap_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP types and constants: state encoding, strobe bundle, instruction codes.
// JTAG_TAP_IDCODE_EN selects IDCODE (vs BYPASS) as the reset instruction.
package jtag_tap_pkg;

  localparam int TAP_IR_W = 4;

  typedef enum logic [3:0] {
    TAP_TLR      = 4'h0,
    TAP_RTI      = 4'h1,
    TAP_SEL_DR   = 4'h2,
    TAP_CAP_DR   = 4'h3,
    TAP_SHIFT_DR = 4'h4,
    TAP_EXIT1_DR = 4'h5,
    TAP_PAUSE_DR = 4'h6,
    TAP_EXIT2_DR = 4'h7,
    TAP_UPD_DR   = 4'h8,
    TAP_SEL_IR   = 4'h9,
    TAP_CAP_IR   = 4'hA,
    TAP_SHIFT_IR = 4'hB,
    TAP_EXIT1_IR = 4'hC,
    TAP_PAUSE_IR = 4'hD,
    TAP_EXIT2_IR = 4'hE,
    TAP_UPD_IR   = 4'hF
  } tap_state_e;

  typedef struct packed {
    logic tlr;
    logic capture_dr;
    logic shift_dr;
    logic pause_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_strb_t;

  localparam logic [TAP_IR_W-1:0] IR_IDCODE  = 4'b0010;
  localparam logic [TAP_IR_W-1:0] IR_DEBUG   = 4'b1000;
  localparam logic [TAP_IR_W-1:0] IR_BYPASS  = 4'b1111;
  localparam logic [TAP_IR_W-1:0] IR_CAPTURE = 4'b0101;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [TAP_IR_W-1:0] IR_RESET = IR_IDCODE;
`else
  localparam logic [TAP_IR_W-1:0] IR_RESET = IR_BYPASS;
`endif

endpackage

// File: rtl/jtag_tap_fsm.sv
// 1149.1 TAP state machine: state register, TMS transition graph and
// combinational per-state strobes.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic      tck_i,
  input  logic      trstn_i,
  input  logic      tms_i,
  output tap_strb_t strb_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) state_q <= TAP_TLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_TLR:      state_d = tms_i ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_d = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   state_d = tms_i ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_d = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      default:      state_d = TAP_TLR;
    endcase
  end

  always_comb begin
    strb_o = '0;
    case (state_q)
      TAP_TLR:      strb_o.tlr        = 1'b1;
      TAP_CAP_DR:   strb_o.capture_dr = 1'b1;
      TAP_SHIFT_DR: strb_o.shift_dr   = 1'b1;
      TAP_PAUSE_DR: strb_o.pause_dr   = 1'b1;
      TAP_UPD_DR:   strb_o.update_dr  = 1'b1;
      TAP_CAP_IR:   strb_o.capture_ir = 1'b1;
      TAP_SHIFT_IR: strb_o.shift_ir   = 1'b1;
      TAP_UPD_IR:   strb_o.update_ir  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS/IDCODE data registers and falling-edge TDO mux.
// JTAG_TAP_IDCODE_EN adds the IDCODE register and makes IDCODE the reset instruction.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH     = TAP_IR_W,
  parameter logic [31:0] IDCODE_VALUE = 32'h2495_11C3
) (
  input  logic tck_i,
  input  logic trstn_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic debug_select_o,
  output logic dbg_tdi_o,
  input  logic dbg_tdo_i
);

  tap_strb_t strb;

  jtag_tap_fsm u_fsm (
    .tck_i   (tck_i),
    .trstn_i (trstn_i),
    .tms_i   (tms_i),
    .strb_o  (strb)
  );

  assign test_logic_reset_o = strb.tlr;
  assign capture_dr_o       = strb.capture_dr;
  assign shift_dr_o         = strb.shift_dr;
  assign pause_dr_o         = strb.pause_dr;
  assign update_dr_o        = strb.update_dr;
  assign dbg_tdi_o          = tdi_i;

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic                idcode_sel, idcode_lsb;

  always_comb begin
    ir_shift_d = ir_shift_q;
    if (strb.capture_ir)    ir_shift_d = IR_CAPTURE;
    else if (strb.shift_ir) ir_shift_d = {tdi_i, ir_shift_q[IR_WIDTH-1:1]};
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) ir_shift_q <= IR_CAPTURE;
    else          ir_shift_q <= ir_shift_d;
  end

  // Latched on the falling edge so selects settle half a cycle before the next rise.
  always_comb begin
    ir_d = ir_q;
    if (strb.tlr)            ir_d = IR_RESET;
    else if (strb.update_ir) ir_d = ir_shift_q;
  end

  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) ir_q <= IR_RESET;
    else          ir_q <= ir_d;
  end

  assign debug_select_o = (ir_q == IR_DEBUG);

  always_comb begin
    bypass_d = bypass_q;
    if (strb.capture_dr)    bypass_d = 1'b0;
    else if (strb.shift_dr) bypass_d = tdi_i;
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) bypass_q <= 1'b0;
    else          bypass_q <= bypass_d;
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;

  always_comb begin
    idcode_d = idcode_q;
    if (strb.capture_dr)    idcode_d = IDCODE_VALUE;
    else if (strb.shift_dr) idcode_d = {tdi_i, idcode_q[31:1]};
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) idcode_q <= IDCODE_VALUE;
    else          idcode_q <= idcode_d;
  end

  assign idcode_sel = (ir_q == IR_IDCODE);
  assign idcode_lsb = idcode_q[0];
`else
  // No IDCODE register: 4'b0010 falls through to BYPASS.
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VALUE;
  assign idcode_sel    = 1'b0;
  assign idcode_lsb    = 1'b0;
`endif

  always_comb begin
    tdo_d    = tdo_q;
    tdo_oe_d = strb.shift_ir | strb.shift_dr;
    if (strb.shift_ir)         tdo_d = ir_shift_q[0];
    else if (strb.shift_dr) begin
      if (debug_select_o)      tdo_d = dbg_tdo_i;
      else if (idcode_sel)     tdo_d = idcode_lsb;
      else                     tdo_d = bypass_q;
    end
  end

  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tdo_o    = tdo_q;
  assign tdo_oe_o = tdo_oe_q;

endmodule
